dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 17 +
 rtl/dmem_rr_pick.sv | 67 ++++++
 rtl/dmem_arbiter.sv | 92 +++++++++
 tb/tb_dmem_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and widths for the data-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_arbiter_pkg;

    localparam int WORD_W        = 16;
    localparam int ADDR_W        = 16;
    localparam int MAX_BURST_DEF = 4;
    // Burst counter width; holds the largest legal MAX_BURST (15).
    localparam int BURST_W       = 4;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// Grant decision between the CPU master (m0) and the loader/debug master (m1).
// Latency: combinational grant; last_owner/burst_cnt update on the granting edge.
// Backpressure: a losing master simply sees no gnt and keeps requesting.
// Build option DMEM_ARBITER_RR_EN: round-robin with MAX_BURST limit; otherwise fixed m0 priority.
import dmem_arbiter_pkg::*;

module dmem_rr_pick #(
    parameter int MAX_BURST = MAX_BURST_DEF
) (
`ifdef DMEM_ARBITER_RR_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic m0_req,
    input  logic m1_req,
    output logic m0_gnt,
    output logic m1_gnt
);

`ifdef DMEM_ARBITER_RR_EN
    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);

    owner_t             last_owner;
    logic [BURST_W-1:0] burst_cnt;
    owner_t             pick;

    // Choose the owner: a lone requester wins outright; on a tie the
    // current owner keeps the bus until its burst reaches the limit.
    // burst_cnt == 0 means no burst history yet (after reset), so the tie
    // goes to the master opposite last_owner, i.e. m0.
    always_comb begin
        pick = OWN_M0;
        if (m0_req && m1_req) begin
            if ((burst_cnt != '0) && (burst_cnt < BURST_LIMIT))
                pick = last_owner;
            else
                pick = (last_owner == OWN_M0) ? OWN_M1 : OWN_M0;
        end else if (m1_req) begin
            pick = OWN_M1;
        end
    end

    assign m0_gnt = m0_req && (pick == OWN_M0);
    assign m1_gnt = m1_req && (pick == OWN_M1);

    // Track the owner and its consecutive-grant count; idle cycles leave both untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= OWN_M1;
            burst_cnt  <= '0;
        end else if (m0_gnt || m1_gnt) begin
            if (pick == last_owner) begin
                if (burst_cnt != '1)
                    burst_cnt <= burst_cnt + 1'b1;
            end else begin
                burst_cnt <= BURST_W'(1);
            end
            last_owner <= pick;
        end
    end
`else
    // Fixed priority: m0 always wins, m1 only gets idle m0 cycles.
    assign m0_gnt = m0_req;
    assign m1_gnt = m1_req && !m0_req;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of a single-port data memory (comb read, edge write).
// Latency: grant and memory access in the request cycle; read data/rvalid one cycle later.
// Backpressure: masters hold req/we/addr/wdata until gnt; no buffering inside.
// Build option DMEM_ARBITER_RR_EN selects round-robin with MAX_BURST, default is fixed m0 priority.
import dmem_arbiter_pkg::*;

module dmem_arbiter #(
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [WORD_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [WORD_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [WORD_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [WORD_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] mem_address,
    output logic [WORD_W-1:0] mem_data_write,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [WORD_W-1:0] mem_data_read
);

    logic pick_m0;
    logic pick_m1;

    dmem_rr_pick #(
        .MAX_BURST (MAX_BURST)
    ) u_pick (
`ifdef DMEM_ARBITER_RR_EN
        .clk       (clk),
        .rst_n     (rst_n),
`endif
        .m0_req    (m0_req),
        .m1_req    (m1_req),
        .m0_gnt    (pick_m0),
        .m1_gnt    (pick_m1)
    );

    // Grants are suppressed while reset is held so no access (and no write) leaks out.
    assign m0_gnt = pick_m0 && rst_n;
    assign m1_gnt = pick_m1 && rst_n;

    // Steer the granted master onto the memory port; park everything at zero when idle.
    always_comb begin
        mem_address    = '0;
        mem_data_write = '0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        if (m0_gnt) begin
            mem_address    = m0_addr;
            mem_data_write = m0_wdata;
            mem_write      = m0_we;
            mem_read       = !m0_we;
        end else if (m1_gnt) begin
            mem_address    = m1_addr;
            mem_data_write = m1_wdata;
            mem_write      = m1_we;
            mem_read       = !m1_we;
        end
    end

    // Capture read data for the granted reader; rdata holds until that master's next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= m0_gnt && !m0_we;
            m1_rvalid <= m1_gnt && !m1_we;
            if (m0_gnt && !m0_we)
                m0_rdata <= mem_data_read;
            if (m1_gnt && !m1_we)
                m1_rdata <= mem_data_read;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

`ifdef DMEM_ARBITER_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [15:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [15:0] m1_addr, m1_wdata, m1_rdata;
    logic [15:0] mem_address, mem_data_write, mem_data_read;
    logic        mem_write, mem_read;

    int n_total = 0;
    int n_bad   = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] ref_mem [0:255];
    logic [15:0] mem     [0:255];

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_BURST(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .m0_req         (m0_req),
        .m0_we          (m0_we),
        .m0_addr        (m0_addr),
        .m0_wdata       (m0_wdata),
        .m0_gnt         (m0_gnt),
        .m0_rvalid      (m0_rvalid),
        .m0_rdata       (m0_rdata),
        .m1_req         (m1_req),
        .m1_we          (m1_we),
        .m1_addr        (m1_addr),
        .m1_wdata       (m1_wdata),
        .m1_gnt         (m1_gnt),
        .m1_rvalid      (m1_rvalid),
        .m1_rdata       (m1_rdata),
        .mem_address    (mem_address),
        .mem_data_write (mem_data_write),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_data_read  (mem_data_read)
    );

    // Data memory: combinational read, write committed on the rising edge.
    assign mem_data_read = mem[mem_address[7:0]];
    always @(posedge clk) begin
        if (mem_write)
            mem[mem_address[7:0]] <= mem_data_write;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every rvalid pulse must match the oldest expected read for that master.
    always @(negedge clk) begin
        if (m0_rvalid) begin
            if (q0.size() == 0) check("m0_unexpected_rvalid", 1, 0);
            else                check("m0_rdata", m0_rdata, q0.pop_front());
        end
        if (m1_rvalid) begin
            if (q1.size() == 0) check("m1_unexpected_rvalid", 1, 0);
            else                check("m1_rdata", m1_rdata, q1.pop_front());
        end
    end

    // One cycle: drive both masters at the falling edge, check grants and the
    // memory port, record expected read data, then advance to the next falling edge.
    task automatic step(input logic r0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                        input logic r1, input logic w1, input logic [15:0] a1, input logic [15:0] d1,
                        input logic eg0, input logic eg1);
        logic [15:0] ea, ed;
        logic        ewe;
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        #1;
        check("m0_gnt", m0_gnt, eg0);
        check("m1_gnt", m1_gnt, eg1);
        ea  = eg0 ? a0 : (eg1 ? a1 : 16'h0);
        ed  = eg0 ? d0 : (eg1 ? d1 : 16'h0);
        ewe = eg0 ? w0 : (eg1 ? w1 : 1'b0);
        check("mem_address", mem_address, ea);
        check("mem_write", mem_write, (eg0 || eg1) && ewe);
        check("mem_read", mem_read, (eg0 || eg1) && !ewe);
        check("mem_data_write", mem_data_write, ewe ? ed : 16'h0);
        if ((eg0 || eg1) && ewe)  ref_mem[ea[7:0]] = ed;
        if (eg0 && !w0)           q0.push_back(ref_mem[a0[7:0]]);
        if (eg1 && !w1)           q1.push_back(ref_mem[a1[7:0]]);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m0_gnt"}, m0_gnt, 0);
        check({tag, "_m1_gnt"}, m1_gnt, 0);
        check({tag, "_m0_rvalid"}, m0_rvalid, 0);
        check({tag, "_m1_rvalid"}, m1_rvalid, 0);
        check({tag, "_m0_rdata"}, m0_rdata, 0);
        check({tag, "_m1_rdata"}, m1_rdata, 0);
        check({tag, "_mem_address"}, mem_address, 0);
        check({tag, "_mem_data_write"}, mem_data_write, 0);
        check({tag, "_mem_write"}, mem_write, 0);
        check({tag, "_mem_read"}, mem_read, 0);
    endtask

    initial begin
        logic eg0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;
        rst_n = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 16'h0; m0_wdata = 16'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 16'h0; m1_wdata = 16'h0;
        repeat (2) @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // m0 alone: write then read back, granted on the first edge after reset.
        step(1, 1, 16'h0010, 16'h1234, 0, 0, 16'h0, 16'h0, 1, 0);
        step(1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0, 16'h0, 1, 0);
        step(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0, 16'h0, 0, 0);

        // m1 write followed directly by m0 read of the same word.
        step(0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0004, 16'h00AA, 0, 1);
        step(1, 0, 16'h0004, 16'h0000, 0, 0, 16'h0, 16'h0, 1, 0);
        step(1, 1, 16'h0010, 16'h5555, 0, 0, 16'h0, 16'h0, 1, 0);
        step(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0, 16'h0, 0, 0);
        check("m0_rdata_hold", m0_rdata, 16'h00AA);

        // m1 read granted, then reset asserted right after the granting edge.
        m0_req = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0004; m1_wdata = 16'h0;
        #1 check("rst_m1_gnt", m1_gnt, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0020; m0_wdata = 16'hDEAD;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0030; m1_wdata = 16'hBEEF;
        @(negedge clk);
        #1 check_all_zero("inreset");
        @(negedge clk);
        check("no_write_in_reset", mem[8'h20], 16'h0000);
        rst_n = 1'b1;

        // Continuous tie of reads: round-robin gives m0 x4, m1 x4, m0 x4; fixed priority gives m0.
        for (int i = 0; i < 12; i++) begin
            eg0 = RR_EN ? (((i / 4) % 2) == 0) : 1'b1;
            step(1, 0, 16'h0010, 16'h0, 1, 0, 16'h0004, 16'h0, eg0, !eg0);
        end
        // m0 drops: m1 granted in that same cycle.
        step(0, 0, 16'h0000, 16'h0, 1, 0, 16'h0004, 16'h0, 0, 1);

        // Partial m0 burst, long idle, then a tie resumes from the held state.
        step(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 1, 0);
        step(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 1, 0);
        for (int i = 0; i < 10; i++)
            step(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            eg0 = RR_EN ? (i < 2) : 1'b1;
            step(1, 0, 16'h0010, 16'h0, 1, 0, 16'h0004, 16'h0, eg0, !eg0);
        end

        // Drain outstanding reads.
        for (int i = 0; i < 3; i++)
            step(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
